// File: rtl/counter_pkg.sv
// Shared definitions for the parametrised up/down counter family.
//   MODE_UP / MODE_DOWN : values of the counter's mode input
//   clog2_safe()        : register width needed to hold 0..value-1, never below 1
package counter_pkg;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  // Bits needed for a counter that runs 0..value-1. A value of 1 still
  // yields a one-bit register so that no zero-width vectors appear.
  function automatic int clog2_safe(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/prescale_tick.sv
// Prescaler for the up/down counter: produces a step qualifier once every
// PRESCALE enabled cycles.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset (clears the prescaler)
//   en   - advance enable; the prescaler holds while en is low
//   clr  - synchronous clear (used on parallel load)
//   tick - combinational: en is high and the prescaler sits on its last value
module prescale_tick
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = clog2_safe(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] ONE  = PW'(1'b1);

  logic [PW-1:0] presc_r;

  // With PRESCALE=1 the register is stuck at 0 and tick simply follows en.
  assign tick = en && (presc_r == LAST);

  // Prescaler state: clear on load, wrap on tick, advance on en, else hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_r <= {PW{1'b0}};
    end else if (clr) begin
      presc_r <= {PW{1'b0}};
    end else if (tick) begin
      presc_r <= {PW{1'b0}};
    end else if (en) begin
      presc_r <= presc_r + ONE;
    end else begin
      presc_r <= presc_r;
    end
  end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with clock enable, prescaler, synchronous
// parallel load, wrap/saturate selection and event flags.
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-low reset
//   en       - count enable (advances prescaler and counter)
//   mode     - 0 count up, 1 count down
//   sat      - 0 wrap at range ends, 1 saturate at range ends
//   load     - synchronous parallel load strobe (overrides stepping)
//   load_val - value to load, clamped to MODULUS-1
//   count    - current count (registered)
//   tc       - terminal count (combinational), usable as a cascade enable
//   wrap     - registered pulse: the previous edge wrapped
//   sat_hit  - registered pulse: the previous step was blocked by saturation
//   load_err - registered pulse: the previous load was clamped
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             sat_hit,
  output logic             load_err
);

  // Reject parameter sets that cannot describe a sensible range.
  generate
    if (WIDTH < 1 || MODULUS < 2 || PRESCALE < 1 ||
        longint'(MODULUS) > (64'sd1 <<< WIDTH)) begin : g_bad_params
      $error("updown_counter_param: illegal WIDTH/MODULUS/PRESCALE");
    end
  endgenerate

  // Range compares are done one bit wider than the count so that
  // MODULUS = 2**WIDTH is representable without aliasing to zero.
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MAX_EXT = {1'b0, MAX_CNT};
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1'b1);

  logic [WIDTH-1:0] count_r;
  logic             wrap_r;
  logic             sat_hit_r;
  logic             load_err_r;

  logic             step_s;
  logic             at_max_s;
  logic             at_zero_s;
  logic             load_ok_s;
  logic [WIDTH-1:0] count_nxt_s;
  logic             wrap_nxt_s;
  logic             sat_hit_nxt_s;
  logic             load_err_nxt_s;

  prescale_tick #(
    .PRESCALE(PRESCALE)
  ) u_prescale (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (load),
    .tick(step_s)
  );

  assign at_max_s  = ({1'b0, count_r} == MAX_EXT);
  assign at_zero_s = (count_r == {WIDTH{1'b0}});
  assign load_ok_s = ({1'b0, load_val} < MOD_EXT);

  // Raised on the cycle whose step would wrap or saturate.
  assign tc = step_s && !load &&
              (((mode == MODE_UP) && at_max_s) || ((mode == MODE_DOWN) && at_zero_s));

  assign count    = count_r;
  assign wrap     = wrap_r;
  assign sat_hit  = sat_hit_r;
  assign load_err = load_err_r;

  // Next-state and event flags: load beats step, step beats hold.
  always_comb begin
    count_nxt_s    = count_r;
    wrap_nxt_s     = 1'b0;
    sat_hit_nxt_s  = 1'b0;
    load_err_nxt_s = 1'b0;
    if (load) begin
      if (load_ok_s) begin
        count_nxt_s = load_val;
      end else begin
        count_nxt_s    = MAX_CNT;
        load_err_nxt_s = 1'b1;
      end
    end else if (step_s) begin
      case (mode)
        MODE_UP: begin
          if (!at_max_s) begin
            count_nxt_s = count_r + ONE_W;
          end else if (sat) begin
            sat_hit_nxt_s = 1'b1;
          end else begin
            count_nxt_s = {WIDTH{1'b0}};
            wrap_nxt_s  = 1'b1;
          end
        end
        MODE_DOWN: begin
          if (!at_zero_s) begin
            count_nxt_s = count_r - ONE_W;
          end else if (sat) begin
            sat_hit_nxt_s = 1'b1;
          end else begin
            count_nxt_s = MAX_CNT;
            wrap_nxt_s  = 1'b1;
          end
        end
        default: begin
          count_nxt_s = count_r;
        end
      endcase
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Count and pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r    <= {WIDTH{1'b0}};
      wrap_r     <= 1'b0;
      sat_hit_r  <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      count_r    <= count_nxt_s;
      wrap_r     <= wrap_nxt_s;
      sat_hit_r  <= sat_hit_nxt_s;
      load_err_r <= load_err_nxt_s;
    end
  end

endmodule
